// File: rtl/sdram_read.sv
// sdram_read: burst read engine issuing one bus read per word and handing each word to a consumer
module sdram_read #(
  parameter int ADDR_STEP = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iaddr,
  input  logic [7:0]  ilen,
  input  logic        ivalid,
  input  logic        iready,
  input  logic [15:0] iData,
  input  logic        iACK,
  output logic [23:0] oAddr,
  output logic        oRead,
  output logic        oWrite,
  output logic [1:0]  oBE,
  output logic [15:0] odata,
  output logic        ovalid,
  output logic        obusy,
  output logic        odone
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  localparam logic [23:0] STEP = 24'(ADDR_STEP);
  state_t      r_state;
  logic [23:0] r_addr;
  logic [7:0]  r_rem;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_done;
  logic        r_read;
  // run sequencing: latch request, wait for ack, hold word until consumer takes it
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_read  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (ivalid && ilen != 8'd0) begin
          r_addr  <= iaddr;
          r_rem   <= ilen;
          r_read  <= 1'b1;
          r_state <= REQ;
        end
        REQ: if (iACK) begin
          r_data  <= iData;
          r_valid <= 1'b1;
          r_read  <= 1'b0;
          r_state <= HOLD;
        end
        HOLD: if (iready) begin
          r_valid <= 1'b0;
          if (r_rem > 8'd1) begin
            r_addr  <= r_addr + STEP;
            r_rem   <= r_rem - 8'd1;
            r_read  <= 1'b1;
            r_state <= REQ;
          end else begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign oRead  = r_read;
  assign oAddr  = r_read ? r_addr : 24'h0;
  assign oWrite = 1'b0;
  assign oBE    = 2'b11;
  assign odata  = r_data;
  assign ovalid = r_valid;
  assign obusy  = r_state != IDLE;
  assign odone  = r_done;
endmodule
